ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_pkg.sv | 36 +++
 rtl/ssd_glyph_dec.sv | 36 +++
 rtl/ssd_scan_ctrl.sv | 92 +++++++++
 tb/tb_ssd_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ============================================================================
//  ssd_pkg -- glyph codes and active-low segment patterns for the scan control
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ssd_pkg;

  localparam logic [4:0] GLYPH_BLANK = 5'h10;
  localparam logic [4:0] GLYPH_P     = 5'h11;
  localparam logic [4:0] GLYPH_L     = 5'h12;
  localparam logic [4:0] GLYPH_DASH  = 5'h13;
  localparam logic [4:0] GLYPH_H     = 5'h14;
  localparam logic [4:0] GLYPH_U     = 5'h15;
  localparam logic [4:0] GLYPH_C     = 5'h16;

  // Bit order g,f,e,d,c,b,a; a 0 lights the segment.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [5:0] BUF_RESET = {1'b0, GLYPH_BLANK};

endpackage

`default_nettype wire

// File: rtl/ssd_glyph_dec.sv
// ============================================================================
//  ssd_glyph_dec -- combinational glyph code + dp to active-low segment byte
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ssd_glyph_dec (
  input  logic [5:0] i_glyph,
  output logic [7:0] o_seg
);
  import ssd_pkg::*;

  logic [6:0] w_pat;

  always_comb begin
    w_pat = SEG_BLANK;
    if (!i_glyph[4]) begin
      w_pat = SEG_HEX[i_glyph[3:0]];
    end else begin
      case (i_glyph[4:0])
        GLYPH_P:    w_pat = SEG_P;
        GLYPH_L:    w_pat = SEG_L;
        GLYPH_DASH: w_pat = SEG_DASH;
        GLYPH_H:    w_pat = SEG_H;
        GLYPH_U:    w_pat = SEG_U;
        GLYPH_C:    w_pat = SEG_C;
        default:    w_pat = SEG_BLANK;
      endcase
    end
  end

  assign o_seg = {~i_glyph[5], w_pat};

endmodule

`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
// ============================================================================
//  ssd_scan_ctrl -- multiplexed seven-segment scanner with PWM brightness
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ssd_scan_ctrl #(
  parameter  int NUM_DIG = 8,
  parameter  int PRESC_W = 15,
  localparam int AW      = $clog2(NUM_DIG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [5:0]         wr_data,
  input  logic [3:0]         bright,
  input  logic               blank_all,
  output logic [7:0]         seg,
  output logic [NUM_DIG-1:0] dig,
  output logic               frame_tick
);
  import ssd_pkg::*;

  logic [5:0]         r_buf [NUM_DIG];
  logic [PRESC_W-1:0] r_presc;
  logic [AW-1:0]      r_idx;
  logic [7:0]         r_seg;
  logic [NUM_DIG-1:0] r_dig;
  logic               r_frame;

  logic               w_wrap;
  logic               w_last;
  logic               w_wr_ok;
  logic               w_lit;
  logic [5:0]         w_cur;
  logic [7:0]         w_seg_dec;

  assign w_wrap  = &r_presc;
  assign w_last  = (r_idx == AW'(NUM_DIG - 1));
  assign w_wr_ok = wr_en && ({1'b0, wr_addr} < (AW + 1)'(NUM_DIG));
  assign w_cur   = r_buf[r_idx];

  // Dark for the first 16 cycles of every dwell, then PWM on the top prescaler nibble.
  assign w_lit = (r_presc[PRESC_W-1:4] != '0) &&
                 ((bright == 4'hF) || (r_presc[PRESC_W-1 -: 4] < bright));

  ssd_glyph_dec u_dec (
    .i_glyph (w_cur),
    .o_seg   (w_seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIG; i++) r_buf[i] <= BUF_RESET;
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_frame <= w_wrap && w_last;
      if (w_wrap) r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 8'hFF;
      r_dig <= '1;
    end else if (blank_all) begin
      r_seg <= 8'hFF;
      r_dig <= '1;
    end else begin
      r_seg <= w_seg_dec;
      r_dig <= w_lit ? ~(NUM_DIG'(1) << r_idx) : '1;
    end
  end

  assign seg        = r_seg;
  assign dig        = r_dig;
  assign frame_tick = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
// ============================================================================
//  tb_ssd_scan_ctrl -- directed bench for an 8-digit and a 5-digit scanner
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ssd_scan_ctrl;

  localparam int PW    = 6;
  localparam int DWELL = 64;

  typedef struct {
    logic [2:0] addr;
    logic [5:0] data;
    logic [7:0] exp_seg;
    logic [7:0] exp_dig;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] bright;
  logic       blank_all;
  logic       wr_en8, wr_en5;
  logic [2:0] wr_addr8, wr_addr5;
  logic [5:0] wr_data8, wr_data5;
  logic [7:0] seg8, seg5;
  logic [7:0] dig8;
  logic [4:0] dig5;
  logic       frame8, frame5;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   low8 [8];
  int   cnt, ft, multi, leak, low4;
  vec_t vecs [12];

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.NUM_DIG(8), .PRESC_W(PW)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en8),
    .wr_addr    (wr_addr8),
    .wr_data    (wr_data8),
    .bright     (bright),
    .blank_all  (blank_all),
    .seg        (seg8),
    .dig        (dig8),
    .frame_tick (frame8)
  );

  ssd_scan_ctrl #(.NUM_DIG(5), .PRESC_W(PW)) u_dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en5),
    .wr_addr    (wr_addr5),
    .wr_data    (wr_data5),
    .bright     (bright),
    .blank_all  (blank_all),
    .seg        (seg5),
    .dig        (dig5),
    .frame_tick (frame5)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // cyc counts edges since reset release; outputs after a tick reflect state cyc-1.
  task automatic tick();
    @(posedge clk);
    if (rst_n) cyc++;
    #1;
  endtask

  function automatic int prev_idx(input int n);
    return ((cyc - 1) / DWELL) % n;
  endfunction

  function automatic int prev_presc();
    return (cyc - 1) % DWELL;
  endfunction

  task automatic wait_state(input int n, input int idx, input int presc);
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(prev_idx(n) == idx && prev_presc() == presc) && guard < 2000);
    if (guard >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_state: timeout, got no match, expected idx %0d presc %0d", idx, presc);
    end
  endtask

  task automatic write8(input logic [2:0] a, input logic [5:0] d);
    wr_en8 = 1'b1; wr_addr8 = a; wr_data8 = d;
    tick();
    wr_en8 = 1'b0;
  endtask

  task automatic write5(input logic [2:0] a, input logic [5:0] d);
    wr_en5 = 1'b1; wr_addr5 = a; wr_data5 = d;
    tick();
    wr_en5 = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'd3, 6'h0E, 8'b10000110, 8'b11110111};
    vecs[1]  = '{3'd0, 6'h20, 8'h40, 8'hFE};
    vecs[2]  = '{3'd5, 6'h11, 8'h8C, 8'hDF};
    vecs[3]  = '{3'd7, 6'h33, 8'h3F, 8'h7F};
    vecs[4]  = '{3'd2, 6'h08, 8'h80, 8'hFB};
    vecs[5]  = '{3'd6, 6'h1F, 8'hFF, 8'hBF};
    vecs[6]  = '{3'd1, 6'h01, 8'hF9, 8'hFD};
    vecs[7]  = '{3'd4, 6'h30, 8'h7F, 8'hEF};
    vecs[8]  = '{3'd3, 6'h16, 8'hC6, 8'hF7};
    vecs[9]  = '{3'd5, 6'h12, 8'hC7, 8'hDF};
    vecs[10] = '{3'd7, 6'h15, 8'hC1, 8'h7F};
    vecs[11] = '{3'd6, 6'h0A, 8'h88, 8'hBF};

    rst_n = 1'b0; bright = 4'hF; blank_all = 1'b0;
    wr_en8 = 1'b0; wr_addr8 = '0; wr_data8 = '0;
    wr_en5 = 1'b0; wr_addr5 = '0; wr_data5 = '0;
    repeat (3) tick();
    check("rst_seg", 16'(seg8), 16'hFF);
    check("rst_dig", 16'(dig8), 16'hFF);
    check("rst_frame", 16'(frame8), 16'h0);
    rst_n = 1'b1;
    cyc = 0;

    // Glyph decode and digit selection
    for (int v = 0; v < 12; v++) begin
      write8(vecs[v].addr, vecs[v].data);
      wait_state(8, int'(vecs[v].addr), 32);
      check($sformatf("vec%0d_dig", v), 16'(dig8), 16'(vecs[v].exp_dig));
      check($sformatf("vec%0d_seg", v), 16'(seg8), 16'(vecs[v].exp_seg));
    end

    // One full frame at full brightness
    wait_state(8, 7, 63);
    for (int b = 0; b < 8; b++) low8[b] = 0;
    ft = 0; multi = 0;
    for (int i = 0; i < 512; i++) begin
      for (int b = 0; b < 8; b++) if (!dig8[b]) low8[b]++;
      if ($countones(~dig8) > 1) multi++;
      if (frame8) ft++;
      if (i == 0) check("frame_at_wrap", 16'(frame8), 16'h1);
      tick();
    end
    for (int b = 0; b < 8; b++) check($sformatf("scan_low_dig%0d", b), 16'(low8[b]), 16'd48);
    check("scan_frame_count", 16'(ft), 16'd1);
    check("scan_multi_low", 16'(multi), 16'd0);

    // Brightness duty over one dwell
    bright = 4'd0; tick(); cnt = 0;
    for (int i = 0; i < 64; i++) begin tick(); cnt += $countones(~dig8); end
    check("bright0_low", 16'(cnt), 16'd0);
    bright = 4'd8; tick(); cnt = 0;
    for (int i = 0; i < 64; i++) begin tick(); cnt += $countones(~dig8); end
    check("bright8_low", 16'(cnt), 16'd16);
    bright = 4'd12; tick(); cnt = 0;
    for (int i = 0; i < 64; i++) begin tick(); cnt += $countones(~dig8); end
    check("bright12_low", 16'(cnt), 16'd32);
    bright = 4'd1; tick(); cnt = 0;
    for (int i = 0; i < 64; i++) begin tick(); cnt += $countones(~dig8); end
    check("bright1_low", 16'(cnt), 16'd0);
    bright = 4'hF;

    // Blank-all: dark from next edge, scan keeps running
    wait_state(8, 2, 32);
    check("preblank_dig", 16'(dig8), 16'hFB);
    blank_all = 1'b1;
    tick();
    check("blank_seg", 16'(seg8), 16'hFF);
    check("blank_dig", 16'(dig8), 16'hFF);
    cnt = 0; ft = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      cnt += $countones(~dig8);
      if (frame8) ft++;
    end
    check("blank_low", 16'(cnt), 16'd0);
    check("blank_frame", 16'(ft), 16'd1);
    blank_all = 1'b0;
    wait_state(8, 2, 32);
    check("unblank_dig", 16'(dig8), 16'hFB);
    check("unblank_seg", 16'(seg8), 16'h80);

    // Rewrite the digit currently on display
    wait_state(8, 1, 30);
    write8(3'd1, 6'h14);
    check("wrlat_old_seg", 16'(seg8), 16'hF9);
    tick(); tick();
    check("wrlat_new_seg", 16'(seg8), 16'h89);
    check("wrlat_dig", 16'(dig8), 16'hFD);

    // Five-digit instance: out-of-range write, wrap 4 -> 0
    write5(3'd6, 6'h08);
    write5(3'd4, 6'h01);
    wait_state(5, 4, 63);
    check("d5_wrap_frame", 16'(frame5), 16'h1);
    check("d5_last_dig", 16'(dig5), 16'h0F);
    check("d5_last_seg", 16'(seg5), 16'hF9);
    wait_state(5, 0, 16);
    check("d5_first_dig", 16'(dig5), 16'h1E);
    check("d5_first_seg", 16'(seg5), 16'hFF);
    ft = 0; leak = 0; low4 = 0;
    for (int i = 0; i < 320; i++) begin
      tick();
      if (frame5) ft++;
      if (!dig5[4]) low4++;
      if ((dig5[3:0] != 4'hF) && (seg5 != 8'hFF)) leak++;
    end
    check("d5_frame_count", 16'(ft), 16'd1);
    check("d5_low_dig4", 16'(low4), 16'd48);
    check("d5_bad_write_leak", 16'(leak), 16'd0);

    // Asynchronous reset mid-dwell
    wait_state(8, 3, 40);
    check("prerst_dig", 16'(dig8), 16'hF7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_seg", 16'(seg8), 16'hFF);
    check("midrst_dig", 16'(dig8), 16'hFF);
    check("midrst_frame", 16'(frame8), 16'h0);
    check("midrst_dig5", 16'(dig5), 16'h1F);
    cyc = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin tick(); cnt += $countones(~dig8); end
    check("postrst_gap_low", 16'(cnt), 16'd0);
    tick();
    check("postrst_dig", 16'(dig8), 16'hFE);
    check("postrst_seg", 16'(seg8), 16'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
